uart_rx_ctrl: RTL and testbench



---
 rtl/uart_rx_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, mid-bit baud clock
// generation for an external receiver, and a small receive FIFO.
//
// Ports:
//   CLK, CLR_N          clock, async active-low reset
//   Serial_in           raw UART line (idle high)
//   Rx_Data/Rx_Ready/Rx_Parity_ERR   receiver result
//   Rx_CLR, CLK_Baud    receiver clear and bit clock
//   Rd_En/Rd_Data/Rd_PErr/Rd_Valid/Fill   FIFO read side
//   Overrun, Frame_ERR, Clear_Status      sticky status
//
// Optional feature: define START_RECHECK_EN to re-check the
// line at mid-start-bit and abort on a false start.
module uart_rx_ctrl #(
   parameter int BAUD_DIV   = 5208,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       CLK,
   input  logic       CLR_N,
   input  logic       Serial_in,
   input  logic [7:0] Rx_Data,
   input  logic       Rx_Ready,
   input  logic       Rx_Parity_ERR,
   output logic       Rx_CLR,
   output logic       CLK_Baud,
   input  logic       Rd_En,
   output logic [7:0] Rd_Data,
   output logic       Rd_PErr,
   output logic       Rd_Valid,
   output logic [4:0] Fill,
   output logic       Overrun,
   output logic       Frame_ERR,
   input  logic       Clear_Status
);

   localparam int HALF = BAUD_DIV / 2;
   localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [15:0] HALF_V  = 16'(HALF);
   localparam logic [15:0] HALF_M1 = 16'(HALF - 1);
   localparam logic [15:0] DIV_M1  = 16'(BAUD_DIV - 1);
   localparam logic [4:0]  DEPTH_V = 5'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      ALIGN,
      FRAME,
      DONE
   } state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [15:0] cnt_inc;
   logic [3:0]  edges;

   logic s1;
   logic s2;
   logic s_prev;
   logic start;

   logic rdy_q;
   logic rdy_rise;
   logic rdy_seen;

   logic done_go;
   logic err_go;

   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [4:0]    count;
   logic          full;
   logic          pop;
   logic          wr;
   logic          ovr_set;

   // Line synchronizer plus one extra flop for edge detect;
   // all reset to the idle (high) level.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         s1     <= 1'b1;
         s2     <= 1'b1;
         s_prev <= 1'b1;
      end else begin
         s1     <= Serial_in;
         s2     <= s1;
         s_prev <= s2;
      end
   end

   assign start = s_prev & ~s2;

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         rdy_q <= 1'b0;
      end else begin
         rdy_q <= Rx_Ready;
      end
   end

   assign rdy_rise = Rx_Ready & ~rdy_q;
   assign cnt_inc  = cnt + 16'd1;

   assign done_go = (state == FRAME) && (cnt == DIV_M1)
                 && (edges == 4'd10);

   // A ready rise landing on the DONE-entry edge still counts.
   assign err_go = done_go & ~(rdy_seen | rdy_rise);

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state    <= IDLE;
         cnt      <= '0;
         edges    <= '0;
         CLK_Baud <= 1'b0;
         Rx_CLR   <= 1'b1;
      end else begin
         Rx_CLR <= err_go;
         unique case (state)
            IDLE: begin
               cnt      <= '0;
               edges    <= '0;
               CLK_Baud <= 1'b0;
               if (start) begin
                  state <= ALIGN;
               end
            end
            ALIGN: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
`ifdef START_RECHECK_EN
                  if (s2) begin
                     state <= IDLE;
                  end else begin
                     state    <= FRAME;
                     CLK_Baud <= 1'b1;
                     edges    <= 4'd1;
                  end
`else
                  state    <= FRAME;
                  CLK_Baud <= 1'b1;
                  edges    <= 4'd1;
`endif
               end else begin
                  cnt <= cnt_inc;
               end
            end
            FRAME: begin
               if (cnt == DIV_M1) begin
                  cnt <= '0;
                  if (edges == 4'd10) begin
                     state    <= DONE;
                     CLK_Baud <= 1'b0;
                  end else begin
                     CLK_Baud <= 1'b1;
                     edges    <= edges + 4'd1;
                  end
               end else begin
                  cnt      <= cnt_inc;
                  CLK_Baud <= (cnt_inc < HALF_V);
               end
            end
            DONE: begin
               state <= IDLE;
               cnt   <= '0;
               edges <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Tracks whether the receiver reported a byte during the
   // current frame; rearmed when a new start is accepted.
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         rdy_seen <= 1'b0;
      end else if ((state == IDLE) && start) begin
         rdy_seen <= rdy_rise;
      end else if (rdy_rise) begin
         rdy_seen <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         Frame_ERR <= 1'b0;
      end else if (err_go) begin
         Frame_ERR <= 1'b1;
      end else if (Clear_Status) begin
         Frame_ERR <= 1'b0;
      end
   end

   assign full    = (count == DEPTH_V);
   assign pop     = Rd_En & (count != 5'd0);
   assign wr      = rdy_rise & (~full | pop);
   assign ovr_set = rdy_rise & full & ~pop;

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (wr) begin
            mem[wp] <= {Rx_Parity_ERR, Rx_Data};
            wp      <= wp + AW'(1);
         end
         if (pop) begin
            rp <= rp + AW'(1);
         end
         if (wr && !pop) begin
            count <= count + 5'd1;
         end else if (!wr && pop) begin
            count <= count - 5'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         Overrun <= 1'b0;
      end else if (ovr_set) begin
         Overrun <= 1'b1;
      end else if (Clear_Status) begin
         Overrun <= 1'b0;
      end
   end

   assign Rd_Data  = mem[rp][7:0];
   assign Rd_PErr  = mem[rp][8];
   assign Rd_Valid = (count != 5'd0);
   assign Fill     = count;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial frames plus a receiver model,
// scoreboard of expected FIFO bytes checked on every pop.
module tb_uart_rx_ctrl;

   localparam int BD = 16;
   localparam int FD = 4;

   logic       CLK = 1'b0;
   logic       CLR_N = 1'b0;
   logic       Serial_in = 1'b1;
   logic [7:0] Rx_Data = 8'h00;
   logic       Rx_Ready = 1'b0;
   logic       Rx_Parity_ERR = 1'b0;
   logic       Rx_CLR;
   logic       CLK_Baud;
   logic       Rd_En = 1'b0;
   logic [7:0] Rd_Data;
   logic       Rd_PErr;
   logic       Rd_Valid;
   logic [4:0] Fill;
   logic       Overrun;
   logic       Frame_ERR;
   logic       Clear_Status = 1'b0;

   uart_rx_ctrl #(
      .BAUD_DIV   (BD),
      .FIFO_DEPTH (FD)
   ) dut (
      .CLK           (CLK),
      .CLR_N         (CLR_N),
      .Serial_in     (Serial_in),
      .Rx_Data       (Rx_Data),
      .Rx_Ready      (Rx_Ready),
      .Rx_Parity_ERR (Rx_Parity_ERR),
      .Rx_CLR        (Rx_CLR),
      .CLK_Baud      (CLK_Baud),
      .Rd_En         (Rd_En),
      .Rd_Data       (Rd_Data),
      .Rd_PErr       (Rd_PErr),
      .Rd_Valid      (Rd_Valid),
      .Fill          (Fill),
      .Overrun       (Overrun),
      .Frame_ERR     (Frame_ERR),
      .Clear_Status  (Clear_Status)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string nm, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, exp);
   endtask

   // Expected {perr, data} of every byte that should be popped.
   logic [8:0] sbq[$];

   always @(negedge CLK) begin
      logic [8:0] e;
      #1;
      if (Rd_En && Rd_Valid) begin
         if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL pop_unexpected: got 0x%0h want none",
                     {Rd_PErr, Rd_Data});
         end else begin
            e = sbq.pop_front();
            check("pop_data", int'({Rd_PErr, Rd_Data}), int'(e));
         end
      end
   end

   // Receiver model: samples the line on CLK_Baud rises and
   // reports a byte after the tenth rise if the start bit was low.
   logic       bprev = 1'b0;
   int         mbits = 0;
   logic [9:0] sh = '0;
   bit         rdy_en = 1'b1;
   bit         pop_on_push = 1'b0;
   bit         clr_on_push = 1'b0;
   bit         own = 1'b0;
   int         rises = 0;
   int         rise_cyc[$];
   int         clr_hi = 0;

   always @(negedge CLK) begin
      Rx_Ready = 1'b0;
      if (own) begin
         Rd_En = 1'b0;
         Clear_Status = 1'b0;
         own = 1'b0;
      end
      if (CLR_N && Rx_CLR) clr_hi++;
      if (!CLR_N || Rx_CLR) begin
         mbits = 0;
      end else if (CLK_Baud && !bprev) begin
         rises++;
         rise_cyc.push_back(cyc);
         sh[mbits] = Serial_in;
         mbits++;
         if (mbits == 10) begin
            mbits = 0;
            if (rdy_en && !sh[0]) begin
               Rx_Data = sh[8:1];
               Rx_Parity_ERR = ^sh[9:1];
               Rx_Ready = 1'b1;
               if (pop_on_push) begin
                  Rd_En = 1'b1;
                  own = 1'b1;
               end
               if (clr_on_push) begin
                  Clear_Status = 1'b1;
                  own = 1'b1;
               end
            end
         end
      end
      bprev = CLK_Baud;
   end

   int c0 = 0;

   task automatic send_frame(input logic [7:0] d, input bit bad);
      logic [10:0] fr;
      fr = {1'b1, (^d) ^ bad, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         @(negedge CLK);
         Serial_in = fr[i];
         if (i == 0) c0 = cyc;
         repeat (BD - 1) @(negedge CLK);
      end
      repeat (8) @(negedge CLK);
   endtask

   task automatic pop_n(input int n);
      repeat (n) begin
         @(negedge CLK);
         Rd_En = 1'b1;
         @(negedge CLK);
         Rd_En = 1'b0;
      end
   endtask

   task automatic pulse_clear();
      @(negedge CLK);
      Clear_Status = 1'b1;
      @(negedge CLK);
      Clear_Status = 1'b0;
      @(negedge CLK);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_valid"}, int'(Rd_Valid), 0);
      check({tag, "_fill"}, int'(Fill), 0);
      check({tag, "_data"}, int'(Rd_Data), 0);
      check({tag, "_perr"}, int'(Rd_PErr), 0);
      check({tag, "_baud"}, int'(CLK_Baud), 0);
      check({tag, "_ovr"}, int'(Overrun), 0);
      check({tag, "_ferr"}, int'(Frame_ERR), 0);
      check({tag, "_rxclr"}, int'(Rx_CLR), 1);
   endtask

   initial begin
      int good;
      repeat (3) @(negedge CLK);
      #1;
      check_reset_outs("rst");
      @(negedge CLK);
      CLR_N = 1'b1;
      @(posedge CLK);
      #1;
      check("rxclr_release", int'(Rx_CLR), 0);
      repeat (4) @(negedge CLK);

      // Single frame: timing of the baud clock and stored byte.
      rises = 0;
      rise_cyc.delete();
      sbq.push_back({1'b0, 8'h5A});
      send_frame(8'h5A, 1'b0);
      check("rise_count", rises, 10);
      if (rise_cyc.size() >= 10) begin
         check("first_rise", rise_cyc[0] - c0, 11);
         good = 0;
         for (int i = 1; i < 10; i++)
            if (rise_cyc[i] - rise_cyc[i-1] == BD) good++;
         check("rise_spacing", good, 9);
      end
      check("f1_fill", int'(Fill), 1);
      check("f1_valid", int'(Rd_Valid), 1);
      check("f1_data", int'(Rd_Data), 'h5A);
      check("f1_perr", int'(Rd_PErr), 0);
      check("f1_ferr", int'(Frame_ERR), 0);
      pop_n(1);
      check("f1_empty", int'(Fill), 0);

      // Parity error stored with the byte.
      sbq.push_back({1'b1, 8'hA5});
      send_frame(8'hA5, 1'b1);
      check("perr_fill", int'(Fill), 1);
      pop_n(1);

      // Overflow; last push coincides with Clear_Status.
      for (int k = 1; k <= 5; k++) begin
         if (k <= FD) sbq.push_back(9'(k));
         clr_on_push = (k == 5);
         send_frame(8'(k), 1'b0);
      end
      clr_on_push = 1'b0;
      check("ovf_fill", int'(Fill), 4);
      check("ovf_overrun", int'(Overrun), 1);
      pulse_clear();
      check("ovf_cleared", int'(Overrun), 0);
      pop_n(4);
      check("ovf_drain_fill", int'(Fill), 0);
      check("ovf_drain_valid", int'(Rd_Valid), 0);

      // Push and pop together while full.
      for (int k = 0; k < 4; k++) begin
         sbq.push_back(9'('h11 + k));
         send_frame(8'('h11 + k), 1'b0);
      end
      check("pp_full", int'(Fill), 4);
      sbq.push_back(9'h006);
      pop_on_push = 1'b1;
      send_frame(8'h06, 1'b0);
      pop_on_push = 1'b0;
      check("pp_fill", int'(Fill), 4);
      check("pp_overrun", int'(Overrun), 0);
      pop_n(4);

      // Frame with no receiver ready.
      rdy_en = 1'b0;
      clr_hi = 0;
      send_frame(8'h33, 1'b0);
      rdy_en = 1'b1;
      check("nordy_rxclr_cycles", clr_hi, 1);
      check("nordy_ferr", int'(Frame_ERR), 1);
      check("nordy_fill", int'(Fill), 0);
      pulse_clear();
      check("nordy_cleared", int'(Frame_ERR), 0);

      // Short low glitch on the line.
      rises = 0;
      clr_hi = 0;
      @(negedge CLK);
      Serial_in = 1'b0;
      repeat (3) @(negedge CLK);
      Serial_in = 1'b1;
      repeat (200) @(negedge CLK);
`ifdef START_RECHECK_EN
      check("glitch_rises", rises, 0);
      check("glitch_ferr", int'(Frame_ERR), 0);
      check("glitch_rxclr", clr_hi, 0);
`else
      check("glitch_rises", rises, 10);
      check("glitch_ferr", int'(Frame_ERR), 1);
      check("glitch_rxclr", clr_hi, 1);
`endif
      check("glitch_fill", int'(Fill), 0);
      pulse_clear();

      // Reset in the middle of a frame.
      sbq.push_back({1'b0, 8'h77});
      send_frame(8'h77, 1'b0);
      check("pre_rst_fill", int'(Fill), 1);
      fork
         send_frame(8'hC3, 1'b0);
         begin
            repeat (80) @(negedge CLK);
            CLR_N = 1'b0;
            #1;
            check_reset_outs("midrst");
            sbq.delete();
         end
      join
      @(negedge CLK);
      CLR_N = 1'b1;
      @(posedge CLK);
      #1;
      check("midrst_release", int'(Rx_CLR), 0);
      repeat (4) @(negedge CLK);
      check("midrst_ferr", int'(Frame_ERR), 0);
      sbq.push_back({1'b0, 8'h3C});
      send_frame(8'h3C, 1'b0);
      check("post_fill", int'(Fill), 1);
      check("post_data", int'(Rd_Data), 'h3C);
      pop_n(1);
      check("post_ferr", int'(Frame_ERR), 0);

      repeat (2) @(negedge CLK);
      check("sb_empty", sbq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
